// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter with port-1 burst lock
// Port 1 may hold the memory across cycles; a counter forces release once port 0 has waited MAX_LOCK grants.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_lock,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

  typedef enum logic [1:0] {
    W_NONE,
    W_P0,
    W_P1
  } winner_e;

  lock_state_e         r_state;
  lock_state_e         w_state_nxt;
  logic                r_prio;
  logic                w_prio_nxt;
  logic [7:0]          r_lock_cnt;
  logic [7:0]          w_lock_cnt_nxt;
  logic [READ_LAT-1:0] r_rd_valid;
  logic [READ_LAT-1:0] r_rd_owner;

  winner_e             w_win;
  logic                w_forced;
  logic                w_sel_we;
  logic                w_push_valid;
  logic                w_push_owner;

  // Winner selection; a saturated counter with port 0 waiting overrides the lock.
  always_comb begin
    w_win    = W_NONE;
    w_forced = (r_state == ST_LOCKED) && i_m0_req && (r_lock_cnt == LOCK_MAX);
    if (!reset) begin
      if ((r_state == ST_LOCKED) && i_m1_req && !w_forced) begin
        w_win = W_P1;
      end else if (i_m0_req && i_m1_req) begin
        w_win = r_prio ? W_P1 : W_P0;
      end else if (i_m0_req) begin
        w_win = W_P0;
      end else if (i_m1_req) begin
        w_win = W_P1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = ST_OPEN;
    w_prio_nxt     = r_prio;
    w_lock_cnt_nxt = 8'd0;
    if ((w_win == W_P1) && i_m1_lock) begin
      w_state_nxt = ST_LOCKED;
    end
    case (w_win)
      W_P0:    w_prio_nxt = 1'b1;
      W_P1:    w_prio_nxt = 1'b0;
      default: w_prio_nxt = r_prio;
    endcase
    // Only locked grants count, and only while port 0 is actually waiting.
    if ((w_win == W_P1) && (r_state == ST_LOCKED)) begin
      if (i_m0_req && (r_lock_cnt < LOCK_MAX)) begin
        w_lock_cnt_nxt = r_lock_cnt + 8'd1;
      end else begin
        w_lock_cnt_nxt = r_lock_cnt;
      end
    end
  end

  always_comb begin
    o_m0_gnt    = 1'b0;
    o_m1_gnt    = 1'b0;
    w_sel_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (w_win)
      W_P0: begin
        o_m0_gnt    = 1'b1;
        w_sel_we    = i_m0_we;
        o_mem_addr  = i_m0_addr;
        o_mem_wdata = i_m0_wdata;
      end
      W_P1: begin
        o_m1_gnt    = 1'b1;
        w_sel_we    = i_m1_we;
        o_mem_addr  = i_m1_addr;
        o_mem_wdata = i_m1_wdata;
      end
      default: begin
        w_sel_we = 1'b0;
      end
    endcase
  end

  assign o_mem_we     = (w_win != W_NONE) && w_sel_we;
  assign o_mem_re     = (w_win != W_NONE) && !w_sel_we;
  assign w_push_valid = o_mem_re;
  assign w_push_owner = (w_win == W_P1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_OPEN;
      r_prio     <= 1'b0;
      r_lock_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Read-return pipe: one slot per cycle of memory latency, tagged with the issuing port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= '0;
      r_rd_owner <= '0;
    end else begin
      for (int i = READ_LAT - 1; i > 0; i--) begin
        r_rd_valid[i] <= r_rd_valid[i-1];
        r_rd_owner[i] <= r_rd_owner[i-1];
      end
      r_rd_valid[0] <= w_push_valid;
      r_rd_owner[0] <= w_push_owner;
    end
  end

  assign o_m0_rvalid = r_rd_valid[READ_LAT-1] && !r_rd_owner[READ_LAT-1];
  assign o_m1_rvalid = r_rd_valid[READ_LAT-1] && r_rd_owner[READ_LAT-1];
  assign o_m0_rdata  = i_mem_rdata;
  assign o_m1_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter at READ_LAT 1 and 3
// Both instances see the same requesters; each has its own memory behind it.
module tb_dmem_arbiter;

  localparam int MAXL = 8;
  localparam int NCYC = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        a_g0, a_g1, a_rv0, a_rv1, a_re, a_we;
  logic [31:0] a_rd0, a_rd1, a_addr, a_wdata, a_mrd;
  logic        b_g0, b_g1, b_rv0, b_rv1, b_re, b_we;
  logic [31:0] b_rd0, b_rd1, b_addr, b_wdata, b_mrd;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .MAX_LOCK(MAXL)) u_dut_a (
    .clk(clk), .reset(reset),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_lock(m1_lock),
    .o_m0_gnt(a_g0), .o_m0_rvalid(a_rv0), .o_m0_rdata(a_rd0),
    .o_m1_gnt(a_g1), .o_m1_rvalid(a_rv1), .o_m1_rdata(a_rd1),
    .o_mem_re(a_re), .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
    .i_mem_rdata(a_mrd)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .MAX_LOCK(MAXL)) u_dut_b (
    .clk(clk), .reset(reset),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_lock(m1_lock),
    .o_m0_gnt(b_g0), .o_m0_rvalid(b_rv0), .o_m0_rdata(b_rd0),
    .o_m1_gnt(b_g1), .o_m1_rvalid(b_rv1), .o_m1_rdata(b_rd1),
    .o_mem_re(b_re), .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
    .i_mem_rdata(b_mrd)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Memories behind the two instances; contents reload while reset is held.
  logic [31:0] a_mem [64];
  logic [31:0] b_mem [64];
  logic [31:0] a_dly [1];
  logic [31:0] b_dly [3];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) a_mem[i] <= init_val(i);
    end else if (a_we) begin
      a_mem[a_addr[5:0]] <= a_wdata;
    end
    a_dly[0] <= a_re ? a_mem[a_addr[5:0]] : 32'h0;
  end
  assign a_mrd = a_dly[0];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) b_mem[i] <= init_val(i);
    end else if (b_we) begin
      b_mem[b_addr[5:0]] <= b_wdata;
    end
    b_dly[0] <= b_re ? b_mem[b_addr[5:0]] : 32'h0;
    b_dly[1] <= b_dly[0];
    b_dly[2] <= b_dly[1];
  end
  assign b_mrd = b_dly[2];

  // Reference model: architectural state plus a per-cycle log of issued reads.
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_win = -1;
  bit          m_prio, m_locked;
  int          m_cnt;
  logic [31:0] ref_mem [64];
  bit          iss_v [NCYC];
  bit          iss_p [NCYC];
  logic [31:0] iss_d [NCYC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_win();
    if (reset) return -1;
    if (m_locked && m1_req && !(m0_req && m_cnt == MAXL)) return 1;
    if (m0_req && m1_req) return m_prio ? 1 : 0;
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  task automatic chk_inst(input string nm, input int lat, input int w,
                          input logic g0, input logic g1, input logic re, input logic we,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic rv0, input logic rv1,
                          input logic [31:0] rd0, input logic [31:0] rd1);
    logic        ev, ep, ewe;
    logic [31:0] ea, ewd;
    ewe = (w == 0) ? m0_we : (w == 1) ? m1_we : 1'b0;
    ea  = (w == 0) ? m0_addr : (w == 1) ? m1_addr : 32'h0;
    ewd = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 32'h0;
    ev  = (cyc >= lat) && iss_v[cyc-lat];
    ep  = (cyc >= lat) && iss_p[cyc-lat];
    check({nm, "_gnt0"}, 32'(g0), 32'(w == 0));
    check({nm, "_gnt1"}, 32'(g1), 32'(w == 1));
    check({nm, "_mem_re"}, 32'(re), 32'((w >= 0) && !ewe));
    check({nm, "_mem_we"}, 32'(we), 32'((w >= 0) && ewe));
    check({nm, "_mem_addr"}, ad, ea);
    check({nm, "_mem_wdata"}, wd, ewd);
    check({nm, "_rvalid0"}, 32'(rv0), 32'(ev && !ep));
    check({nm, "_rvalid1"}, 32'(rv1), 32'(ev && ep));
    if (ev) check({nm, "_rdata"}, ep ? rd1 : rd0, iss_d[cyc-lat]);
  endtask

  task automatic step();
    int w;
    @(negedge clk);
    if (reset) begin
      m_prio = 0; m_locked = 0; m_cnt = 0;
      for (int i = 0; i < NCYC; i++) iss_v[i] = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    end
    w = model_win();
    chk_inst("A", 1, w, a_g0, a_g1, a_re, a_we, a_addr, a_wdata, a_rv0, a_rv1, a_rd0, a_rd1);
    chk_inst("B", 3, w, b_g0, b_g1, b_re, b_we, b_addr, b_wdata, b_rv0, b_rv1, b_rd0, b_rd1);
    last_win = w;
    if (w >= 0) m_prio = (w == 0);
    if (w == 1 && m_locked) begin
      if (m0_req && m_cnt < MAXL) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    m_locked = (w == 1) && m1_lock;
    iss_v[cyc] = 0;
    if (w == 0) begin
      if (m0_we) ref_mem[m0_addr[5:0]] = m0_wdata;
      else begin iss_v[cyc] = 1; iss_p[cyc] = 0; iss_d[cyc] = ref_mem[m0_addr[5:0]]; end
    end else if (w == 1) begin
      if (m1_we) ref_mem[m1_addr[5:0]] = m1_wdata;
      else begin iss_v[cyc] = 1; iss_p[cyc] = 1; iss_d[cyc] = ref_mem[m1_addr[5:0]]; end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    m0_req = 0; m1_req = 0; m1_lock = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    for (int i = 0; i < n; i++) step();
    reset = 0;
  endtask

  // A held request keeps its command; a granted or idle port draws a new random one.
  task automatic refill();
    if (last_win == 0 || !m0_req) begin
      m0_req = ($urandom % 4) != 0; m0_we = $urandom % 2;
      m0_addr = $urandom % 64; m0_wdata = $urandom;
    end
    if (last_win == 1 || !m1_req) begin
      m1_req = ($urandom % 4) != 0; m1_we = $urandom % 2;
      m1_addr = $urandom % 64; m1_wdata = $urandom;
    end
    m1_lock = ($urandom % 8) != 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    do_reset(3);

    // Single port-0 read of 0x10
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    step();
    check("t1_first_grant", 32'(last_win), 32'd0);
    m0_req = 0;
    idle(4);

    // Both ports reading continuously, fresh from reset
    do_reset(2);
    m0_req = 1; m0_we = 0; m0_addr = 32'h4;
    m1_req = 1; m1_we = 0; m1_addr = 32'h24;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_alternate", 32'(last_win), 32'(k % 2));
      if (last_win == 0) m0_addr = 32'(($urandom % 16) * 4);
      if (last_win == 1) m1_addr = 32'(($urandom % 16) * 4);
    end
    idle(4);

    // Port-1 locked burst with port 0 idle, then port 0 arrives
    m1_req = 1; m1_we = 1; m1_lock = 1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      m1_addr = $urandom % 64; m1_wdata = $urandom;
      step();
      if (last_win == 1) n++;
    end
    check("t3_burst_grants", 32'(n), 32'd20);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      m1_addr = $urandom % 64; m1_wdata = $urandom;
      step();
      if (last_win == 0) break;
      n++;
    end
    check("t3_lock_wait", 32'(n), 32'(MAXL));
    check("t3_port0_won", 32'(last_win), 32'd0);
    m0_req = 0;
    idle(4);

    // Write from port 1 then read of the same address from port 0
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55; m1_lock = 0;
    step();
    check("t4_write_first", 32'(last_win), 32'd1);
    m1_req = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    step();
    check("t4_read_second", 32'(last_win), 32'd0);
    idle(5);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      refill();
      step();
    end
    idle(5);

    // Reset with reads in flight
    m0_req = 1; m0_we = 0; m0_addr = 32'h4;
    m1_req = 1; m1_we = 0; m1_addr = 32'h8; m1_lock = 0;
    step();
    if (last_win == 0) m0_req = 0;
    if (last_win == 1) m1_req = 0;
    step();
    m0_req = 1; m1_req = 1;
    do_reset(3);
    m0_req = 0; m1_req = 0;
    idle(5);
    m0_req = 1; m0_we = 0; m0_addr = 32'hC;
    m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    step();
    check("t6_post_reset_grant", 32'(last_win), 32'd0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port data memory between the core load/store path (port 0) and a loader/DMA engine (port 1). It sits between the requesters and the data memory. It issues at most one memory command per cycle, tracks which port owns each in-flight read, and returns read data to the correct port. Port 1 may lock the memory for bursts, bounded by a counter so the core cannot starve.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- READ_LAT, 1, cycles from accepted read command to valid mem_rdata (1..4)
- MAX_LOCK, 8, maximum consecutive port-1 grants while port 0 is requesting (2..255)

Ports (x = 0,1):
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- mx_req  in  1  port x requests an access; held with command stable until mx_gnt
- mx_we  in  1  1 = write, 0 = read
- mx_addr  in  ADDR_W  access address
- mx_wdata  in  DATA_W  write data
- m1_lock  in  1  port 1 requests to keep ownership on the next cycle (burst)
- mx_gnt  out  1  command accepted this cycle (combinational)
- mx_rvalid  out  1  read data for port x valid this cycle
- mx_rdata  out  DATA_W  read data; equals mem_rdata, meaningful only with mx_rvalid
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after mem_re

## Operation
- Registered state:
  - prio: port with priority next; reset 0.
  - locked: port 1 holds ownership; reset 0.
  - lock_cnt: 8-bit count of consecutive locked grants; reset 0.
  - rd_pipe: READ_LAT-deep shift register of {valid, owner}; reset all 0.
- Winner selection, combinational, each cycle:
  - If locked and m1_req and not (m0_req and lock_cnt == MAX_LOCK): winner = 1.
  - Otherwise, if both ports request: winner = prio.
  - Otherwise: winner = the single requesting port; none if neither requests.
- At most one mx_gnt is high in any cycle. mem_addr, mem_wdata and mem_we/mem_re come from the winner. With no winner, mem_re = mem_we = 0 and addr/wdata = 0.
- After a grant to port x, prio <= other port (round-robin). prio is unchanged when there is no grant.
- Lock behaviour:
  - On a port-1 grant with m1_lock = 1: locked <= 1.
  - lock_cnt increments, saturating at MAX_LOCK, only when m0_req is high. It resets to 0 on any cycle without a locked port-1 grant.
  - locked <= 0 when port 1 is granted with m1_lock = 0, when m1_req drops, or on a forced release (lock_cnt == MAX_LOCK with m0_req). On a forced release, port 0 wins that cycle.
- Read return:
  - An accepted read pushes {1, owner} into rd_pipe. Writes push {0, -}.
  - On the cycle the entry reaches the pipe output, m<owner>_rvalid = 1.
  - Read data returns in issue order. The requester must accept data the cycle it is presented; there is no backpressure.
- Writes complete at the grant edge and produce no rvalid.

## Timing
- Grant latency: 0 cycles. mx_gnt rises in the same cycle as mx_req if that port wins. The command is consumed at the following posedge.
- Read data latency: mx_rvalid is high exactly READ_LAT cycles after the mx_gnt cycle.
- Throughput: one command per cycle, with back-to-back grants allowed.
- Worst-case port-0 wait:
  - Unlocked: 1 cycle.
  - Locked: MAX_LOCK cycles after m0_req rises.
- Simultaneous events:
  - Both requesting with prio = 0 and unlocked: port 0 wins.
  - m1_lock with m1_req low has no effect.
- Reset mid-operation clears rd_pipe. Pending reads are dropped without rvalid. Requesters must reissue after reset deassert.
- Outputs during reset: gnt, rvalid, mem_re and mem_we are 0; addr/wdata/rdata-path outputs are 0 or don't-care.

## Test plan
- Single port-0 read of addr 0x10, memory returns 0xDEADBEEF: m0_gnt in cycle 0, m0_rvalid and m0_rdata = 0xDEADBEEF in cycle READ_LAT, m1 signals all 0.
- Both ports continuously requesting reads, unlocked: grants alternate 0,1,0,1 starting from port 0 after reset. Each rvalid is routed to the correct port in order.
- Port 1 burst of 20 writes with m1_lock = 1 while port 0 is idle: 20 consecutive m1_gnt and lock_cnt stays 0. Then m0_req rises: port 0 is granted after MAX_LOCK = 8 port-1 grants, and locked clears.
- Interleaved write(0x20, 0x55) from port 1 and read(0x20) from port 0 in consecutive cycles: write granted first, and the read returns 0x55 to port 0 only.
- Reset asserted with two reads in flight: no rvalid on either port afterward, all outputs 0, and the first grant after release goes to port 0 when both request.
- READ_LAT = 3 with back-to-back reads alternating ports: rvalid sequence matches the grant order, delayed exactly 3 cycles.
